// File: rtl/frame_writer_pkg.sv
// Shared encodings for the double-buffered LED frame writer: command opcodes,
// pixel colour encoding, controller states and the default matrix size.
package frame_writer_pkg;

  localparam int DIM_DEFAULT = 16;

  typedef enum logic [1:0] {
    OP_NOP    = 2'b00,
    OP_WRITE  = 2'b01,
    OP_CLEAR  = 2'b10,
    OP_COMMIT = 2'b11
  } cmd_op_t;

  typedef enum logic [1:0] {
    COLOR_OFF   = 2'b00,
    COLOR_RED   = 2'b01,
    COLOR_GREEN = 2'b10,
    COLOR_AMBER = 2'b11
  } color_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_CLEAR     = 2'b01,
    ST_WAIT_SYNC = 2'b10
  } fw_state_t;

  // Colour bit 0 drives the red plane, bit 1 the green plane.
  function automatic logic color_red(input logic [1:0] color);
    return color[0];
  endfunction

  function automatic logic color_grn(input logic [1:0] color);
    return color[1];
  endfunction

endpackage

// File: rtl/frame_writer.sv
// Double-buffered frame writer for a DIM x DIM red/green LED matrix.
// Commands edit a back buffer; COMMIT copies it to the displayed front buffer.
// Optional feature macro: FRAME_WRITER_VSYNC_EN -- when defined, a COMMIT waits
// for the scan driver's vsync pulse; otherwise it completes on the next cycle.
module frame_writer
  import frame_writer_pkg::*;
#(
  parameter int DIM = DIM_DEFAULT
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     cmd_valid,
  input  logic [1:0]               cmd_op,
  input  logic [3:0]               cmd_x,
  input  logic [3:0]               cmd_y,
  input  logic [1:0]               cmd_color,
  output logic                     cmd_ready,
  input  logic                     vsync,
  output logic [DIM-1:0][DIM-1:0]  RedPixels,
  output logic [DIM-1:0][DIM-1:0]  GrnPixels,
  output logic                     commit_done,
  output logic [7:0]               frame_count
);

  localparam int ROW_W = (DIM > 1) ? $clog2(DIM) : 1;
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(DIM - 1);

  fw_state_t                state;
  logic [ROW_W-1:0]         row_cnt;
  logic [DIM-1:0][DIM-1:0]  back_red;
  logic [DIM-1:0][DIM-1:0]  back_grn;
  logic                     cmd_take;
  logic                     sync_hit;

  assign cmd_take = cmd_valid && cmd_ready;

`ifdef FRAME_WRITER_VSYNC_EN
  assign sync_hit = vsync;
`else
  // vsync is deliberately ignored: a pending commit fires on the next cycle.
  // The OR keeps the port referenced without changing the result.
  assign sync_hit = vsync | 1'b1;
`endif

  // Controller FSM, back-buffer edits, row-wise clear and front-buffer swap.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= ST_IDLE;
      cmd_ready   <= 1'b0;
      row_cnt     <= '0;
      commit_done <= 1'b0;
      frame_count <= 8'd0;
      back_red    <= '0;
      back_grn    <= '0;
      RedPixels   <= '0;
      GrnPixels   <= '0;
    end else begin
      commit_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_take) begin
            case (cmd_op_t'(cmd_op))
              OP_WRITE: begin
                back_red[cmd_y][cmd_x] <= color_red(cmd_color);
                back_grn[cmd_y][cmd_x] <= color_grn(cmd_color);
              end
              OP_CLEAR: begin
                state     <= ST_CLEAR;
                row_cnt   <= '0;
                cmd_ready <= 1'b0;
              end
              OP_COMMIT: begin
                state     <= ST_WAIT_SYNC;
                cmd_ready <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        ST_CLEAR: begin
          back_red[row_cnt] <= '0;
          back_grn[row_cnt] <= '0;
          row_cnt           <= row_cnt + 1'b1;
          if (row_cnt == ROW_LAST) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b1;
          end
        end
        ST_WAIT_SYNC: begin
          if (sync_hit) begin
            RedPixels   <= back_red;
            GrnPixels   <= back_grn;
            frame_count <= frame_count + 8'd1;
            commit_done <= 1'b1;
            state       <= ST_IDLE;
            cmd_ready   <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          cmd_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_writer.sv
// Randomized bench for frame_writer with a transaction-level reference model
// of the back/front pixel planes and the commit counter.
`timescale 1ns/1ps
module tb_frame_writer;
  import frame_writer_pkg::*;

  localparam int DIM = 16;

  logic                     CLK = 1'b0;
  logic                     RST = 1'b0;
  logic                     cmd_valid = 1'b0;
  logic [1:0]               cmd_op = 2'b00;
  logic [3:0]               cmd_x = 4'd0;
  logic [3:0]               cmd_y = 4'd0;
  logic [1:0]               cmd_color = 2'b00;
  logic                     vsync = 1'b0;
  logic                     cmd_ready;
  logic                     commit_done;
  logic [DIM-1:0][DIM-1:0]  RedPixels;
  logic [DIM-1:0][DIM-1:0]  GrnPixels;
  logic [7:0]               frame_count;

  frame_writer #(.DIM(DIM)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .cmd_valid   (cmd_valid),
    .cmd_op      (cmd_op),
    .cmd_x       (cmd_x),
    .cmd_y       (cmd_y),
    .cmd_color   (cmd_color),
    .cmd_ready   (cmd_ready),
    .vsync       (vsync),
    .RedPixels   (RedPixels),
    .GrnPixels   (GrnPixels),
    .commit_done (commit_done),
    .frame_count (frame_count)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: pixel planes as plain [row][col] arrays plus a commit tally.
  bit mr[16][16];
  bit mg[16][16];
  bit fr[16][16];
  bit fg[16][16];
  int m_frames = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] flat(input bit p[16][16]);
    logic [255:0] v;
    v = '0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        v[r*16 + c] = p[r][c];
    return v;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        mr[r][c] = 1'b0; mg[r][c] = 1'b0; fr[r][c] = 1'b0; fg[r][c] = 1'b0;
      end
    m_frames = 0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_front(input string tag);
    chk({tag, "_red"}, RedPixels, flat(fr));
    chk({tag, "_grn"}, GrnPixels, flat(fg));
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 100) begin
      tick();
      n++;
    end
    if (!cmd_ready) chk("ready_timeout", 256'(cmd_ready), 256'(1));
  endtask

  // Offer one command for one cycle once the DUT is ready; it is taken at that edge.
  task automatic send(input logic [1:0] op, input logic [3:0] x, input logic [3:0] y,
                      input logic [1:0] c, input logic vs);
    wait_ready();
    cmd_valid = 1'b1; cmd_op = op; cmd_x = x; cmd_y = y; cmd_color = c; vsync = vs;
    tick();
    cmd_valid = 1'b0; cmd_op = 2'b00; vsync = 1'b0;
  endtask

  task automatic garbage_cmd();
    cmd_valid = 1'b1;
    cmd_op    = 2'($urandom_range(0, 3));
    cmd_x     = 4'($urandom);
    cmd_y     = 4'($urandom);
    cmd_color = 2'($urandom);
  endtask

  task automatic do_write(input logic [3:0] x, input logic [3:0] y, input logic [1:0] c);
    send(2'b01, x, y, c, 1'b0);
    mr[y][x] = c[0];
    mg[y][x] = c[1];
    chk("write_ready", 256'(cmd_ready), 256'(1));
    chk("write_front_red", RedPixels, flat(fr));
  endtask

  task automatic do_clear();
    int n = 0;
    send(2'b10, 4'd0, 4'd0, 2'b00, 1'b0);
    while (!cmd_ready && n < 40) begin
      garbage_cmd();
      tick();
      n++;
    end
    cmd_valid = 1'b0;
    chk("clear_busy_cycles", 256'(n), 256'(16));
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        mr[r][c] = 1'b0; mg[r][c] = 1'b0;
      end
    chk_front("clear_front");
    chk("clear_no_done", 256'(commit_done), 256'(0));
  endtask

  // vsync_same: drive vsync on the acceptance cycle; dly: idle WAIT_SYNC cycles before vsync.
  task automatic do_commit(input logic vsync_same, input int dly);
    send(2'b11, 4'd0, 4'd0, 2'b00, vsync_same);
`ifdef FRAME_WRITER_VSYNC_EN
    for (int i = 0; i < dly; i++) begin
      garbage_cmd();
      tick();
      chk("wait_no_swap_red", RedPixels, flat(fr));
      chk("wait_no_done", 256'(commit_done), 256'(0));
    end
    cmd_valid = 1'b0;
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
`else
    if (dly < 0) $display("note: negative delay");
    tick();
`endif
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        fr[r][c] = mr[r][c]; fg[r][c] = mg[r][c];
      end
    m_frames++;
    chk_front("commit_front");
    chk("commit_done_pulse", 256'(commit_done), 256'(1));
    chk("commit_count", 256'(frame_count), 256'(m_frames % 256));
    chk("commit_ready", 256'(cmd_ready), 256'(1));
    tick();
    chk("commit_done_single", 256'(commit_done), 256'(0));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_red"}, RedPixels, 256'(0));
    chk({tag, "_grn"}, GrnPixels, 256'(0));
    chk({tag, "_count"}, 256'(frame_count), 256'(0));
    chk({tag, "_done"}, 256'(commit_done), 256'(0));
    chk({tag, "_ready"}, 256'(cmd_ready), 256'(0));
  endtask

  task automatic release_reset();
    RST = 1'b1;
    model_reset();
    tick();
    chk("ready_after_reset", 256'(cmd_ready), 256'(1));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    RST = 1'b0;
    repeat (3) tick();
    chk_reset_outputs("reset");
    release_reset();

    // Single write lands in the back buffer only.
    do_write(4'd3, 4'd5, 2'b11);
    chk("front_dark_before_commit", RedPixels, 256'(0));
    do_commit(1'b0, 4);
    chk("px_5_3_red", 256'(RedPixels[5][3]), 256'(1));
    chk("px_5_3_grn", 256'(GrnPixels[5][3]), 256'(1));
    chk("first_frame_count", 256'(frame_count), 256'(1));

    // Three pixels, clear, front stays until the next commit.
    do_write(4'd0, 4'd0, 2'b01);
    do_write(4'd15, 4'd15, 2'b10);
    do_write(4'd7, 4'd9, 2'b11);
    do_commit(1'b0, 1);
    do_clear();
    do_commit(1'b0, 2);

    // Commit accepted together with vsync must still wait for a later pulse.
    do_write(4'd2, 4'd12, 2'b01);
    do_commit(1'b1, 3);

    // Randomized traffic.
    for (int k = 0; k < 300; k++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel <= 5) begin
        do_write(4'($urandom), 4'($urandom), 2'($urandom));
      end else if (sel == 6) begin
        send(2'b00, 4'($urandom), 4'($urandom), 2'($urandom), 1'b0);
        chk("nop_ready", 256'(cmd_ready), 256'(1));
        chk_front("nop_front");
      end else if (sel == 7) begin
        do_clear();
      end else if (sel == 8) begin
        do_commit(1'($urandom), $urandom_range(0, 5));
      end else begin
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        chk_front("idle_vsync_front");
        chk("idle_vsync_no_done", 256'(commit_done), 256'(0));
      end
    end

    // Reset in the middle of a clear (row 7 being zeroed).
    do_write(4'd1, 4'd1, 2'b11);
    do_write(4'd8, 4'd10, 2'b01);
    do_commit(1'b0, 0);
    send(2'b10, 4'd0, 4'd0, 2'b00, 1'b0);
    repeat (7) tick();
    #2;
    RST = 1'b0;
    #1;
    chk_reset_outputs("mid_clear_reset");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_hold_no_done", 256'(commit_done), 256'(0));
    end
    release_reset();
    chk_front("post_reset_front");
    chk("post_reset_count", 256'(frame_count), 256'(0));

    // 256 commits wrap the frame counter back to zero.
    for (int k = 0; k < 256; k++) begin
      if (($urandom & 3) == 0) do_write(4'($urandom), 4'($urandom), 2'($urandom));
      do_commit(1'b0, $urandom_range(0, 2));
    end
    chk("frame_count_wrap", 256'(frame_count), 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
